// File: rtl/video_timing_gen.sv
// Raster timing generator: HS/VS/DE, pixel X, source line Y_SRC, line-buffer
// read address and line/frame strobes from one pixel clock, with horizontal
// pixel replication, vertical line repetition and frame-lock to an external
// SYNC pulse.
// Optional feature macro: VTG_TEST_PATTERN_EN (adds PATTERN input and R/G/B
// colour-bar outputs aligned with DE).
module video_timing_gen #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned H_FP        = 40,
  parameter int unsigned H_SYNC      = 128,
  parameter int unsigned H_BP        = 88,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned V_FP        = 1,
  parameter int unsigned V_SYNC      = 4,
  parameter int unsigned V_BP        = 23,
  parameter int unsigned HS_POL      = 1,
  parameter int unsigned VS_POL      = 1,
  parameter int unsigned H_DIV_LOG2  = 0,
  parameter int unsigned LINE_REPEAT = 1,
  parameter int unsigned LOCK_LINE   = 0,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned CW          = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              SYNC,
  input  logic              SYNC_EN,
`ifdef VTG_TEST_PATTERN_EN
  input  logic              PATTERN,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
`endif
  output logic              HS,
  output logic              VS,
  output logic              DE,
  output logic [CW-1:0]     X,
  output logic [CW-1:0]     Y_SRC,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              LINE_START,
  output logic              FRAME_START,
  output logic              LOCKED
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] REP_LAST = CW'(LINE_REPEAT - 1);
  localparam logic [CW-1:0] LOCK_V   = CW'(LOCK_LINE);
  localparam logic          HS_ON    = 1'(HS_POL);
  localparam logic          VS_ON    = 1'(VS_POL);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] rep_cnt;
  logic [CW-1:0] ysrc_cnt;
  logic          sync_q;
  logic          lock_pend;

  logic h_wrap;
  logic v_wrap;
  logic sync_rise;
  logic lock_now;
  logic line_active;
  logic hs_act;
  logic vs_act;
  logic de_c;

  // Counter decode: wraps, lock condition and sync/active windows
  always_comb begin
    h_wrap      = (h_cnt == H_LAST);
    v_wrap      = (v_cnt == V_LAST);
    sync_rise   = SYNC & ~sync_q & SYNC_EN;
    // An edge landing on the wrap clock is applied at that same wrap
    lock_now    = h_wrap & ENABLE & SYNC_EN & (lock_pend | sync_rise);
    line_active = (v_cnt < V_ACT);
    hs_act      = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_act      = (v_cnt >= VS_START) && (v_cnt < VS_END);
    de_c        = (h_cnt < H_ACT) && line_active;
  end

  // Raster counters; a lock reloads v_cnt but never touches h_cnt
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      rep_cnt  <= '0;
      ysrc_cnt <= '0;
    end else if (ENABLE) begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (lock_now) begin
          v_cnt    <= LOCK_V;
          rep_cnt  <= '0;
          ysrc_cnt <= '0;
        end else if (v_wrap) begin
          v_cnt    <= '0;
          rep_cnt  <= '0;
          ysrc_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + CW'(1);
          if (line_active) begin
            if (rep_cnt == REP_LAST) begin
              rep_cnt  <= '0;
              ysrc_cnt <= ysrc_cnt + CW'(1);
            end else begin
              rep_cnt <= rep_cnt + CW'(1);
            end
          end
        end
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // SYNC edge detection, pending-lock flag and sticky LOCKED
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync_q    <= 1'b0;
      lock_pend <= 1'b0;
      LOCKED    <= 1'b0;
    end else begin
      sync_q <= SYNC;
      if (!SYNC_EN || lock_now) begin
        lock_pend <= 1'b0;
      end else if (sync_rise) begin
        lock_pend <= 1'b1;
      end
      if (lock_now) begin
        LOCKED <= 1'b1;
      end
    end
  end

  // Registered video outputs; strobes and DE drop while disabled
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      HS          <= ~HS_ON;
      VS          <= ~VS_ON;
      DE          <= 1'b0;
      X           <= '0;
      Y_SRC       <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else if (ENABLE) begin
      HS          <= hs_act ? HS_ON : ~HS_ON;
      VS          <= vs_act ? VS_ON : ~VS_ON;
      DE          <= de_c;
      X           <= h_cnt;
      Y_SRC       <= ysrc_cnt;
      LINE_START  <= (h_cnt == '0) && line_active;
      FRAME_START <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      DE          <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end
  end

  // Unregistered read address so synchronous BRAM data lands with DE
  always_comb begin
    BRAM_ADDR = '0;
    if (h_cnt < H_ACT) begin
      BRAM_ADDR = ADDR_W'(h_cnt >> H_DIV_LOG2);
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  logic [2:0] bar_idx;

  // Eight vertical colour bars across the active width
  always_comb begin
    bar_idx = 3'((32'(h_cnt) * 32'd8) / H_ACTIVE);
  end

  // Pattern pixels, registered alongside DE
  always_ff @(posedge CLK) begin
    if (!RESET || !ENABLE || !de_c || !PATTERN) begin
      R <= 8'h00;
      G <= 8'h00;
      B <= 8'h00;
    end else begin
      R <= {8{bar_idx[2]}};
      G <= {8{bar_idx[1]}};
      B <= {8{bar_idx[0]}};
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a small raster (H 8/2/2/2, V 4/1/1/1),
// 2x pixel replication, 2x line repeat and lock line 5.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int DIV = 1, REP = 2, LOCKL = 5;
  localparam int CW = 12, AW = 14;

  logic clk = 1'b0;
  logic rst, en, sync, sync_en;
  logic hs, vs, de, ls, fs, locked;
  logic [CW-1:0] x, y_src;
  logic [AW-1:0] bram_addr;
`ifdef VTG_TEST_PATTERN_EN
  logic pattern;
  logic [7:0] r, g, b;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .H_DIV_LOG2(DIV), .LINE_REPEAT(REP),
    .LOCK_LINE(LOCKL), .ADDR_W(AW), .CW(CW)
  ) dut (
    .CLK(clk), .RESET(rst), .ENABLE(en), .SYNC(sync), .SYNC_EN(sync_en),
`ifdef VTG_TEST_PATTERN_EN
    .PATTERN(pattern), .R(r), .G(g), .B(b),
`endif
    .HS(hs), .VS(vs), .DE(de), .X(x), .Y_SRC(y_src), .BRAM_ADDR(bram_addr),
    .LINE_START(ls), .FRAME_START(fs), .LOCKED(locked)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: raster position plus count of active lines shown since
  // the frame began (or since the last lock)
  int m_h = 0, m_v = 0, m_act = 0;
  bit m_pend = 0, m_prev = 0, m_locked = 0, m_rise, m_valid = 0;
  bit e_hs = 0, e_vs = 0, e_de = 0, e_ls = 0, e_fs = 0;
  int e_x = 0, e_y = 0, e_r = 0, e_g = 0, e_b = 0, bar;
  bit pat_in;

  always @(posedge clk) begin
    m_valid = 1;
`ifdef VTG_TEST_PATTERN_EN
    pat_in = pattern;
`else
    pat_in = 0;
`endif
    if (!rst) begin
      m_h = 0; m_v = 0; m_act = 0; m_pend = 0; m_prev = 0; m_locked = 0;
      e_hs = 0; e_vs = 0; e_de = 0; e_ls = 0; e_fs = 0; e_x = 0; e_y = 0;
      e_r = 0; e_g = 0; e_b = 0;
    end else begin
      m_rise = sync && !m_prev && sync_en;
      m_prev = sync;
      if (en) begin
        e_hs = (m_h >= HA + HF) && (m_h < HA + HF + HSY);
        e_vs = (m_v >= VA + VF) && (m_v < VA + VF + VSY);
        e_de = (m_h < HA) && (m_v < VA);
        e_ls = (m_h == 0) && (m_v < VA);
        e_fs = (m_h == 0) && (m_v == 0);
        e_x  = m_h;
        e_y  = m_act / REP;
        bar  = (m_h * 8) / HA;
        e_r  = (pat_in && e_de && bar[2]) ? 255 : 0;
        e_g  = (pat_in && e_de && bar[1]) ? 255 : 0;
        e_b  = (pat_in && e_de && bar[0]) ? 255 : 0;
      end else begin
        e_de = 0; e_ls = 0; e_fs = 0; e_r = 0; e_g = 0; e_b = 0;
      end
      if (!sync_en) m_pend = 0;
      else if (m_rise) m_pend = 1;
      if (en) begin
        if (m_h == HT - 1) begin
          m_h = 0;
          if (m_pend) begin
            m_v = LOCKL; m_act = 0; m_pend = 0; m_locked = 1;
          end else begin
            if (m_v < VA) m_act++;
            m_v = (m_v + 1) % VT;
            if (m_v == 0) m_act = 0;
          end
        end else begin
          m_h++;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("hs", hs, e_hs);
      chk("vs", vs, e_vs);
      chk("de", de, e_de);
      chk("x", x, e_x);
      chk("y_src", y_src, e_y);
      chk("line_start", ls, e_ls);
      chk("frame_start", fs, e_fs);
      chk("locked", locked, m_locked);
      chk("bram_addr", bram_addr, (m_h < HA) ? (m_h >> DIV) : 0);
`ifdef VTG_TEST_PATTERN_EN
      chk("r", r, e_r);
      chk("g", g, e_g);
      chk("b", b, e_b);
`endif
    end
  end

  int addr_lit [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int ysrc_lit [4] = '{0, 0, 1, 1};
  int ys [4];
  int fs_cyc [2];
  int nls, nfs, x_held;
  bit found;

  initial begin
    rst = 0; en = 1; sync = 0; sync_en = 1;
`ifdef VTG_TEST_PATTERN_EN
    pattern = 1;
`endif
    repeat (3) @(negedge clk);
    chk("reset_de", de, 0);
    chk("reset_hs", hs, 0);
    chk("reset_x", x, 0);

    // First line/frame after release
    rst = 1;
    nls = 0; nfs = 0;
    for (int i = 0; i <= 110; i++) begin
      if (i < 8) chk("lit_bram_addr", bram_addr, addr_lit[i]);
      if (i < 14) begin
        chk("lit_de", de, (i >= 1 && i <= 8) ? 1 : 0);
        chk("lit_hs", hs, (i == 11 || i == 12) ? 1 : 0);
`ifdef VTG_TEST_PATTERN_EN
        chk("lit_rgb", {r[0], g[0], b[0]}, (i >= 1 && i <= 8) ? i - 1 : 0);
`endif
      end
      if (fs) begin
        if (nfs < 2) fs_cyc[nfs] = i;
        nfs++;
      end
      if (ls && nls < 4) begin
        ys[nls] = int'(y_src);
        nls++;
      end
      @(negedge clk);
    end
    chk("lit_fs_count", nfs, 2);
    chk("lit_fs_first", fs_cyc[0], 1);
    chk("lit_fs_period", fs_cyc[1] - fs_cyc[0], HT * VT);
    chk("lit_ls_count", nls, 4);
    for (int k = 0; k < 4; k++) chk("lit_ysrc", ys[k], ysrc_lit[k]);

    // Frame lock: edge at v=2,h=3, then an edge on the wrap clock itself
    rst = 0;
    @(negedge clk);
    rst = 1;
    for (int c = 0; c <= 92; c++) begin
      if (c == 31) sync = 1;
      if (c == 33) sync = 0;
      if (c == 41) chk("lit_locked_before", locked, 0);
      if (c == 42) chk("lit_locked_after", locked, 1);
      if (c == 43) begin
        chk("lit_lock1_vs", vs, 1);
        chk("lit_lock1_de", de, 0);
      end
      if (c == 70) chk("lit_fs_not_yet", fs, 0);
      if (c == 71) chk("lit_fs_after_lock", fs, 1);
      if (c == 83) sync = 1;
      if (c == 85) begin
        chk("lit_lock2_vs", vs, 1);
        chk("lit_lock2_de", de, 0);
      end
      if (c == 86) sync = 0;
      if (c == 88) sync_en = 0;
      if (c == 89) sync = 1;
      if (c == 90) sync = 0;
      if (c == 92) sync_en = 1;
      @(negedge clk);
    end

    // ENABLE low for 20 clocks mid-line
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (de && x == CW'(3)) found = 1;
      else @(negedge clk);
    end
    chk("wait_mid_line", found, 1);
    x_held = int'(x);
    en = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("lit_hold_de", de, 0);
      chk("lit_hold_x", x, x_held);
    end
    en = 1;
    @(negedge clk);
    chk("lit_resume_x", x, x_held + 1);
    chk("lit_resume_de", de, 1);

    // Reset asserted mid active line
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (de && x == CW'(5)) found = 1;
      else @(negedge clk);
    end
    chk("wait_active", found, 1);
    rst = 0;
    @(negedge clk);
    chk("lit_rst_de", de, 0);
    chk("lit_rst_hs", hs, 0);
    chk("lit_rst_vs", vs, 0);
    chk("lit_rst_addr", bram_addr, 0);
    chk("lit_rst_locked", locked, 0);
    chk("lit_rst_x", x, 0);
    rst = 1;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator for the VGA/ADV output path. Successor to the fixed-mode TX timing logic.
- Generates HS/VS/DE, the active pixel X/Y, line-buffer read address, and line/frame strobes from one pixel clock.
- Adds horizontal pixel replication, vertical line repetition, and frame-lock to the RX-side SYNC pulse.
- Sits between TX_PLL output clock and the line-buffer read port / ADV DAC.

Parameters:
H_ACTIVE, 800, active pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, horizontal sync width
H_BP, 88, horizontal back porch
V_ACTIVE, 600, active lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width
V_BP, 23, vertical back porch
HS_POL, 1, HS level when asserted
VS_POL, 1, VS level when asserted
H_DIV_LOG2, 0, each source pixel is shown for 2^H_DIV_LOG2 clocks
LINE_REPEAT, 1, each source line is shown LINE_REPEAT times (>=1)
LOCK_LINE, 0, v_cnt value loaded when a frame-lock is applied
ADDR_W, 14, BRAM_ADDR width
CW, 12, X/Y and counter width

Ports:
CLK  in  1  pixel clock
RESET  in  1  synchronous, active-low reset
ENABLE  in  1  counters advance when high
SYNC  in  1  frame-lock request from RX, level; rising edge detected internally
SYNC_EN  in  1  1 = honour SYNC
HS  out  1  horizontal sync, polarity HS_POL
VS  out  1  vertical sync, polarity VS_POL
DE  out  1  active-video qualifier
X  out  CW  active pixel column (h_cnt)
Y_SRC  out  CW  source line index (v_cnt / LINE_REPEAT)
BRAM_ADDR  out  ADDR_W  line-buffer read address
LINE_START  out  1  1-clock pulse, first active pixel of each line
FRAME_START  out  1  1-clock pulse, first active pixel of line 0
LOCKED  out  1  high after a SYNC lock has been applied; cleared by reset

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Active region comes first in each line and each frame.
- Counters:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - On wrap, v_cnt increments; v_cnt wraps V_TOTAL-1 -> 0.
  - rep_cnt counts 0..LINE_REPEAT-1 across active lines. On rep_cnt wrap, ysrc_cnt increments.
  - rep_cnt and ysrc_cnt clear when v_cnt wraps.
- Decode from the registered counters:
  - hs_act = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vs_act is the same rule on v_cnt.
  - de = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Latency: HS, VS, DE, X, Y_SRC, LINE_START and FRAME_START are registered, 1 clock after the counter state.
- BRAM_ADDR is driven combinationally from the counters, so synchronous-read BRAM data aligns with DE:
  - BRAM_ADDR = h_cnt >> H_DIV_LOG2, truncated/zero-extended to ADDR_W, when h_cnt<H_ACTIVE.
  - BRAM_ADDR = 0 otherwise.
- ENABLE=0:
  - All counters hold.
  - DE, LINE_START and FRAME_START are forced 0.
  - HS, VS, X and Y_SRC hold their last values.
- Frame lock:
  - A rising edge on SYNC (registered previous value compared with current) while SYNC_EN=1 sets lock_pend.
  - At the next h_cnt wrap, v_cnt loads LOCK_LINE instead of incrementing. rep_cnt and ysrc_cnt clear, lock_pend clears, LOCKED sets.
  - If the rising edge falls in the same clock as the h wrap, it is applied at that wrap.
  - A second edge while lock_pend is set is absorbed.
  - SYNC_EN=0 clears lock_pend.
  - h_cnt is never modified by a lock.
- Reset (RESET=0 at a CLK edge, any time including mid-line):
  - All counters 0, lock_pend 0, sync-edge register 0.
  - HS=~HS_POL, VS=~VS_POL, DE=0, X=0, Y_SRC=0, LINE_START=0, FRAME_START=0, LOCKED=0.
  - BRAM_ADDR=0 follows from the counters.
- Width rules: CW must hold H_TOTAL-1 and V_TOTAL-1. X is h_cnt; the counter bits drive X directly with no divide.

Optional Feature:
Macro VTG_TEST_PATTERN_EN.
- Defined: adds input PATTERN (1) and outputs R, G, B (8 each), registered and aligned with DE.
  - With PATTERN=1 and DE=1, the output is 8 vertical colour bars: bar index = X*8/H_ACTIVE, bit2->R, bit1->G, bit0->B, each 8'hFF or 8'h00.
  - R/G/B = 0 whenever DE=0, PATTERN=0, or during reset.
- Undefined: the ports and logic are absent and the remaining behaviour is unchanged.

Test Plan:
All tests use H 8/2/2/2, V 4/1/1/1 (H_TOTAL=14, V_TOTAL=7).
1. Release reset, ENABLE=1 -> first DE high for 8 clocks starting 1 clock after release. HS low-to-high (HS_POL=1) for 2 clocks at h_cnt 10-11. Line period 14 clocks, frame period 98 clocks. FRAME_START once per 98.
2. H_DIV_LOG2=1, LINE_REPEAT=2 -> BRAM_ADDR sequence 0,0,1,1,2,2,3,3 per line. Y_SRC sequence 0,0,1,1 over active lines 0-3.
3. LOCK_LINE=5, SYNC pulse at v_cnt=2, h_cnt=3 -> at the next wrap v_cnt=5 and LOCKED=1. FRAME_START occurs 2 lines later. Repeat with the SYNC edge exactly at h_cnt=13 -> applied at that wrap.
4. ENABLE low for 20 clocks mid-line -> DE=0 throughout, counters frozen, timing resumes from the frozen h_cnt.
5. Assert RESET=0 mid-active line -> next clock DE=0, HS/VS inactive, BRAM_ADDR=0, LOCKED=0.
6. VTG_TEST_PATTERN_EN defined, PATTERN=1, H_ACTIVE=8 -> per-pixel RGB = 000,001,...,111, and 0 during blanking.
